// File: rtl/modport_alu.sv
// ---------------------------------------------------------------------------
// modport_alu
//   Registered, parameterised integer ALU.
//   - mode=1: arithmetic commands. mode=0: logical commands.
//   - Single-cycle latency for all commands except MUL_INC and MUL_SHL,
//     which register their result one edge after they are accepted.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        asynchronous active-high reset
//   i_ce         clock enable; when 0 all outputs hold
//   i_mode       1 = arithmetic, 0 = logical
//   i_cin        carry/borrow in (ADD_CIN / SUB_CIN only)
//   i_inp_valid  bit0 = opa valid, bit1 = opb valid
//   i_cmd        operation code
//   i_opa/i_opb  operands
//   o_res        result, DATA_WIDTH+1 bits
//   o_oflow      borrow / underflow flag
//   o_cout       carry out
//   o_g/o_l/o_e  compare flags A>B, A<B, A==B
//   o_err        illegal command or required operand not valid
//   o_busy       debug view of the two-state multiply FSM (1 = multiply pending)
//
// Handshake: a command is taken on every rising edge with i_ce=1 while the
// unit is not busy. While a multiply is pending (o_busy=1) inputs are
// ignored and the multiply completes on the next edge regardless of i_ce.
// ---------------------------------------------------------------------------
module modport_alu #(
    parameter int DATA_WIDTH = 8,
    parameter int CMD_WIDTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ce,
    input  logic                  i_mode,
    input  logic                  i_cin,
    input  logic [1:0]            i_inp_valid,
    input  logic [CMD_WIDTH-1:0]  i_cmd,
    input  logic [DATA_WIDTH-1:0] i_opa,
    input  logic [DATA_WIDTH-1:0] i_opb,
    output logic [DATA_WIDTH:0]   o_res,
    output logic                  o_oflow,
    output logic                  o_cout,
    output logic                  o_g,
    output logic                  o_l,
    output logic                  o_e,
    output logic                  o_err,
    output logic                  o_busy
);

    localparam int DW  = DATA_WIDTH;
    localparam int SHW = $clog2(DATA_WIDTH);

    // Arithmetic command codes (mode=1)
    localparam logic [CMD_WIDTH-1:0] A_ADD     = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] A_SUB     = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] A_ADD_CIN = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] A_SUB_CIN = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] A_INC_A   = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] A_DEC_A   = CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0] A_INC_B   = CMD_WIDTH'(6);
    localparam logic [CMD_WIDTH-1:0] A_DEC_B   = CMD_WIDTH'(7);
    localparam logic [CMD_WIDTH-1:0] A_CMP     = CMD_WIDTH'(8);
    localparam logic [CMD_WIDTH-1:0] A_MUL_INC = CMD_WIDTH'(9);
    localparam logic [CMD_WIDTH-1:0] A_MUL_SHL = CMD_WIDTH'(10);

    // Logical command codes (mode=0)
    localparam logic [CMD_WIDTH-1:0] L_AND     = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] L_NAND    = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] L_OR      = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] L_NOR     = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] L_XOR     = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] L_XNOR    = CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0] L_NOT_A   = CMD_WIDTH'(6);
    localparam logic [CMD_WIDTH-1:0] L_NOT_B   = CMD_WIDTH'(7);
    localparam logic [CMD_WIDTH-1:0] L_SHR1_A  = CMD_WIDTH'(8);
    localparam logic [CMD_WIDTH-1:0] L_SHL1_A  = CMD_WIDTH'(9);
    localparam logic [CMD_WIDTH-1:0] L_SHR1_B  = CMD_WIDTH'(10);
    localparam logic [CMD_WIDTH-1:0] L_SHL1_B  = CMD_WIDTH'(11);
    localparam logic [CMD_WIDTH-1:0] L_ROL_A_B = CMD_WIDTH'(12);
    localparam logic [CMD_WIDTH-1:0] L_ROR_A_B = CMD_WIDTH'(13);

    // Multiply FSM states
    localparam logic S_IDLE = 1'b0;
    localparam logic S_MUL  = 1'b1;

    localparam logic [DW:0] ONE = (DW+1)'(1);

    // Registered outputs and multiply state
    logic          r_state;
    logic [DW:0]   r_res;
    logic          r_oflow, r_cout, r_g, r_l, r_e, r_err;
    logic [DW:0]   r_ma, r_mb;

    // Combinational next values for a single-cycle command
    logic [DW:0]   w_a9, w_b9, w_cin9, w_mul;
    logic [DW:0]   w_res;
    logic          w_oflow, w_cout, w_g, w_l, w_e, w_err;
    logic          w_start_mul;
    logic [DW:0]   w_ma, w_mb;
    logic          w_need_a, w_need_b, w_illegal;
    logic [SHW-1:0] w_sh;
    logic          w_sh_hi;
    logic [DW-1:0] w_rol, w_ror;

    assign w_a9   = {1'b0, i_opa};
    assign w_b9   = {1'b0, i_opb};
    assign w_cin9 = {{DW{1'b0}}, i_cin};
    assign w_mul  = r_ma * r_mb;   // truncated to DW+1 bits by width

    // Rotate amount uses only the low log2(DW) bits of B; any set bit
    // above that flags an error but the rotated value is still output.
    assign w_sh    = i_opb[SHW-1:0];
    assign w_sh_hi = |i_opb[DW-1:SHW];
    assign w_rol   = (i_opa << w_sh) | (i_opa >> (DW - int'(w_sh)));
    assign w_ror   = (i_opa >> w_sh) | (i_opa << (DW - int'(w_sh)));

    always_comb begin
        w_res       = '0;
        w_oflow     = 1'b0;
        w_cout      = 1'b0;
        w_g         = 1'b0;
        w_l         = 1'b0;
        w_e         = 1'b0;
        w_err       = 1'b0;
        w_start_mul = 1'b0;
        w_ma        = '0;
        w_mb        = '0;
        w_need_a    = 1'b1;
        w_need_b    = 1'b1;
        w_illegal   = 1'b0;

        // Operand requirements and legality of the command code
        if (i_mode) begin
            if (i_cmd == A_INC_A || i_cmd == A_DEC_A) w_need_b = 1'b0;
            if (i_cmd == A_INC_B || i_cmd == A_DEC_B) w_need_a = 1'b0;
            if (i_cmd > A_MUL_SHL)                    w_illegal = 1'b1;
        end else begin
            if (i_cmd == L_NOT_A || i_cmd == L_SHR1_A || i_cmd == L_SHL1_A) w_need_b = 1'b0;
            if (i_cmd == L_NOT_B || i_cmd == L_SHR1_B || i_cmd == L_SHL1_B) w_need_a = 1'b0;
            if (i_cmd > L_ROR_A_B)                                          w_illegal = 1'b1;
        end

        if (w_illegal || (w_need_a && !i_inp_valid[0]) || (w_need_b && !i_inp_valid[1])) begin
            w_err = 1'b1;
        end else if (i_mode) begin
            case (i_cmd)
                A_ADD:     begin w_res = w_a9 + w_b9;          w_cout = w_res[DW]; end
                A_SUB:     begin w_res = w_a9 - w_b9;          w_oflow = (w_a9 < w_b9); end
                A_ADD_CIN: begin w_res = w_a9 + w_b9 + w_cin9; w_cout = w_res[DW]; end
                A_SUB_CIN: begin w_res = w_a9 - w_b9 - w_cin9; w_oflow = (w_a9 < (w_b9 + w_cin9)); end
                A_INC_A:   begin w_res = w_a9 + ONE;           w_cout = w_res[DW]; end
                A_DEC_A:   begin w_res = w_a9 - ONE;           w_oflow = (i_opa == '0); end
                A_INC_B:   begin w_res = w_b9 + ONE;           w_cout = w_res[DW]; end
                A_DEC_B:   begin w_res = w_b9 - ONE;           w_oflow = (i_opb == '0); end
                A_CMP: begin
                    w_g = (i_opa > i_opb);
                    w_l = (i_opa < i_opb);
                    w_e = (i_opa == i_opb);
                end
                A_MUL_INC: begin w_start_mul = 1'b1; w_ma = w_a9 + ONE;       w_mb = w_b9 + ONE; end
                A_MUL_SHL: begin w_start_mul = 1'b1; w_ma = {i_opa, 1'b0};    w_mb = w_b9; end
                default:   w_err = 1'b1;
            endcase
        end else begin
            case (i_cmd)
                L_AND:     w_res = {1'b0, i_opa & i_opb};
                L_NAND:    w_res = {1'b0, ~(i_opa & i_opb)};
                L_OR:      w_res = {1'b0, i_opa | i_opb};
                L_NOR:     w_res = {1'b0, ~(i_opa | i_opb)};
                L_XOR:     w_res = {1'b0, i_opa ^ i_opb};
                L_XNOR:    w_res = {1'b0, ~(i_opa ^ i_opb)};
                L_NOT_A:   w_res = {1'b0, ~i_opa};
                L_NOT_B:   w_res = {1'b0, ~i_opb};
                L_SHR1_A:  w_res = {1'b0, i_opa >> 1};
                L_SHL1_A:  w_res = {1'b0, i_opa << 1};
                L_SHR1_B:  w_res = {1'b0, i_opb >> 1};
                L_SHL1_B:  w_res = {1'b0, i_opb << 1};
                L_ROL_A_B: begin w_res = {1'b0, w_rol}; w_err = w_sh_hi; end
                L_ROR_A_B: begin w_res = {1'b0, w_ror}; w_err = w_sh_hi; end
                default:   w_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_res   <= '0;
            r_oflow <= 1'b0;
            r_cout  <= 1'b0;
            r_g     <= 1'b0;
            r_l     <= 1'b0;
            r_e     <= 1'b0;
            r_err   <= 1'b0;
            r_ma    <= '0;
            r_mb    <= '0;
        end else if (r_state == S_MUL) begin
            // Second multiply edge completes even with i_ce low.
            r_state <= S_IDLE;
            r_res   <= w_mul;
            r_oflow <= 1'b0;
            r_cout  <= 1'b0;
            r_g     <= 1'b0;
            r_l     <= 1'b0;
            r_e     <= 1'b0;
            r_err   <= 1'b0;
        end else if (i_ce) begin
            if (w_start_mul) begin
                // Outputs hold on the accept edge; only operands are captured.
                r_state <= S_MUL;
                r_ma    <= w_ma;
                r_mb    <= w_mb;
            end else begin
                r_res   <= w_res;
                r_oflow <= w_oflow;
                r_cout  <= w_cout;
                r_g     <= w_g;
                r_l     <= w_l;
                r_e     <= w_e;
                r_err   <= w_err;
            end
        end
    end

    assign o_res   = r_res;
    assign o_oflow = r_oflow;
    assign o_cout  = r_cout;
    assign o_g     = r_g;
    assign o_l     = r_l;
    assign o_e     = r_e;
    assign o_err   = r_err;
    assign o_busy  = r_state;

endmodule

// File: tb/tb_modport_alu.sv
module tb_modport_alu;

  typedef struct packed {
    logic [8:0] res;
    logic       oflow;
    logic       cout;
    logic       g;
    logic       l;
    logic       e;
    logic       err;
  } out_t;

  logic       clk, rst, ce, mode, cin;
  logic [1:0] inp_valid;
  logic [3:0] cmd;
  logic [7:0] opa, opb;
  logic [8:0] res;
  logic       oflow, cout, g, l, e, err, busy;

  int   n_checks = 0;
  int   n_fails  = 0;
  out_t exp_out;
  out_t pend_out;
  bit   pend;

  modport_alu #(.DATA_WIDTH(8), .CMD_WIDTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_mode(mode), .i_cin(cin),
    .i_inp_valid(inp_valid), .i_cmd(cmd), .i_opa(opa), .i_opb(opb),
    .o_res(res), .o_oflow(oflow), .o_cout(cout), .o_g(g), .o_l(l), .o_e(e),
    .o_err(err), .o_busy(busy)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t observed();
    out_t o;
    o.res = res; o.oflow = oflow; o.cout = cout;
    o.g = g; o.l = l; o.e = e; o.err = err;
    return o;
  endfunction

  // Reference model: plain integer arithmetic on the command table.
  // Returns expected outputs and whether the command is a two-cycle multiply.
  function automatic out_t model(input bit m, input int c, input int a, input int b,
                                 input int ci, input bit [1:0] iv, output bit is_mul);
    out_t r;
    int need, v, s;
    bit illegal;
    r = '0;
    is_mul = 1'b0;
    if (m) begin
      illegal = (c >= 11);
      need = (c == 4 || c == 5) ? 1 : (c == 6 || c == 7) ? 2 : 3;
    end else begin
      illegal = (c >= 14);
      need = (c == 6 || c == 8 || c == 9) ? 1 : (c == 7 || c == 10 || c == 11) ? 2 : 3;
    end
    if (illegal || ((int'(iv) & need) != need)) begin
      r.err = 1'b1;
      return r;
    end
    if (m) begin
      case (c)
        0:  begin v = a + b;      r.res = 9'(v); r.cout = (v >= 512 || v >= 256); end
        1:  begin r.res = 9'((a - b) & 511); r.oflow = (a < b); end
        2:  begin v = a + b + ci; r.res = 9'(v); r.cout = (v >= 256); end
        3:  begin r.res = 9'((a - b - ci) & 511); r.oflow = (a < b + ci); end
        4:  begin v = a + 1; r.res = 9'(v); r.cout = (v >= 256); end
        5:  begin r.res = 9'((a - 1) & 511); r.oflow = (a == 0); end
        6:  begin v = b + 1; r.res = 9'(v); r.cout = (v >= 256); end
        7:  begin r.res = 9'((b - 1) & 511); r.oflow = (b == 0); end
        8:  begin r.g = (a > b); r.l = (a < b); r.e = (a == b); end
        9:  begin r.res = 9'(((a + 1) * (b + 1)) % 512); is_mul = 1'b1; end
        default: begin r.res = 9'(((a * 2) * b) % 512); is_mul = 1'b1; end
      endcase
    end else begin
      s = b % 8;
      case (c)
        0:  r.res = 9'(a & b);
        1:  r.res = 9'(255 - (a & b));
        2:  r.res = 9'(a | b);
        3:  r.res = 9'(255 - (a | b));
        4:  r.res = 9'(a ^ b);
        5:  r.res = 9'(255 - (a ^ b));
        6:  r.res = 9'(255 - a);
        7:  r.res = 9'(255 - b);
        8:  r.res = 9'(a / 2);
        9:  r.res = 9'((a * 2) % 256);
        10: r.res = 9'(b / 2);
        11: r.res = 9'((b * 2) % 256);
        12: begin r.res = 9'(((a * (1 << s)) + (a / (1 << (8 - s)))) % 256); r.err = (b >= 8); end
        default: begin r.res = 9'(((a / (1 << s)) + ((a * (1 << (8 - s))) % 256)) % 256); r.err = (b >= 8); end
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string tag, input out_t got, input out_t want);
    n_checks++;
    assert (got === want) else begin
      n_fails++;
      $error("FAIL %s: observed res=%h of=%b co=%b g=%b l=%b e=%b err=%b expected res=%h of=%b co=%b g=%b l=%b e=%b err=%b",
             tag, got.res, got.oflow, got.cout, got.g, got.l, got.e, got.err,
             want.res, want.oflow, want.cout, want.g, want.l, want.e, want.err);
    end
  endtask

  task automatic drive(input bit m, input int c, input int a, input int b,
                       input bit ci, input bit [1:0] iv, input bit en);
    mode = m; cmd = 4'(c); opa = 8'(a); opb = 8'(b); cin = ci; inp_valid = iv; ce = en;
  endtask

  // One clock: predict from the driven inputs, clock, then compare.
  task automatic step(input string tag);
    out_t r;
    bit   is_mul;
    r = model(mode, int'(cmd), int'(opa), int'(opb), int'(cin), inp_valid, is_mul);
    @(posedge clk);
    #1;
    if (pend) begin
      exp_out = pend_out;
      pend = 1'b0;
    end else if (ce) begin
      if (is_mul) begin
        pend = 1'b1;
        pend_out = r;
      end else begin
        exp_out = r;
      end
    end
    chk(tag, observed(), exp_out);
  endtask

  function automatic out_t mk(input int r, input bit of, input bit co,
                              input bit gg, input bit ll, input bit ee, input bit er);
    out_t o;
    o.res = 9'(r); o.oflow = of; o.cout = co; o.g = gg; o.l = ll; o.e = ee; o.err = er;
    return o;
  endfunction

  initial begin
    pend = 1'b0;
    exp_out = '0;
    drive(1, 0, 0, 0, 0, 2'b11, 1);
    rst = 1'b1;
    #12;
    chk("reset_state", observed(), mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-multiply: outputs clear immediately, no result afterwards.
    drive(1, 0, 8'hFF, 8'hFF, 0, 2'b11, 1);
    step("pre_add");
    drive(1, 9, 3, 4, 0, 2'b11, 1);
    step("mul_accept_hold");
    #2 rst = 1'b1;
    #1;
    chk("async_reset_clear", observed(), mk(0, 0, 0, 0, 0, 0, 0));
    pend = 1'b0; exp_out = '0;
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 2'b11, 0);
    step("no_result_after_reset");
    chk("no_result_after_reset_const", observed(), mk(0, 0, 0, 0, 0, 0, 0));

    drive(1, 0, 8'hFF, 8'h01, 0, 2'b11, 1);
    step("add_ff_01");
    chk("add_ff_01_const", observed(), mk(9'h100, 0, 1, 0, 0, 0, 0));

    drive(1, 1, 3, 5, 0, 2'b11, 1);
    step("sub_3_5");
    chk("sub_3_5_const", observed(), mk(9'h1FE, 1, 0, 0, 0, 0, 0));
    drive(1, 3, 5, 3, 1, 2'b11, 1);
    step("subcin_5_3");
    chk("subcin_5_3_const", observed(), mk(1, 0, 0, 0, 0, 0, 0));

    drive(1, 8, 5, 5, 0, 2'b11, 1);
    step("cmp_eq");
    chk("cmp_eq_const", observed(), mk(0, 0, 0, 0, 0, 1, 0));
    drive(1, 8, 7, 2, 0, 2'b11, 1);
    step("cmp_gt");
    chk("cmp_gt_const", observed(), mk(0, 0, 0, 1, 0, 0, 0));

    // Multiply: hold on first edge, busy-cycle input dropped, result on second.
    drive(1, 9, 3, 4, 0, 2'b11, 1);
    step("mulinc_first_edge");
    chk("mulinc_hold_const", observed(), mk(0, 0, 0, 1, 0, 0, 0));
    drive(1, 0, 1, 1, 0, 2'b11, 1);
    step("mulinc_second_edge");
    chk("mulinc_result_const", observed(), mk(20, 0, 0, 0, 0, 0, 0));
    drive(1, 10, 8'h81, 3, 0, 2'b11, 1);
    step("mulshl_first_edge");
    drive(1, 0, 9, 9, 0, 2'b11, 0);
    step("mulshl_ce0_completes");

    drive(0, 4, 8'hAA, 8'h0F, 0, 2'b11, 1);
    step("xor");
    chk("xor_const", observed(), mk(8'hA5, 0, 0, 0, 0, 0, 0));
    drive(0, 12, 8'h81, 1, 0, 2'b11, 1);
    step("rol_1");
    chk("rol_1_const", observed(), mk(8'h03, 0, 0, 0, 0, 0, 0));
    drive(0, 12, 8'h81, 8'h10, 0, 2'b11, 1);
    step("rol_err");
    chk("rol_err_const", observed(), mk(8'h81, 0, 0, 0, 0, 0, 1));
    drive(0, 13, 8'h81, 2, 0, 2'b11, 1);
    step("ror_2");

    drive(1, 0, 4, 4, 0, 2'b01, 1);
    step("add_b_invalid");
    chk("add_b_invalid_const", observed(), mk(0, 0, 0, 0, 0, 0, 1));
    drive(1, 15, 4, 4, 0, 2'b11, 1);
    step("cmd15");
    chk("cmd15_const", observed(), mk(0, 0, 0, 0, 0, 0, 1));
    drive(1, 4, 8'hFF, 0, 0, 2'b01, 1);
    step("inca_ff");
    drive(1, 0, 1, 2, 0, 2'b11, 0);
    step("ce0_hold");
    chk("ce0_hold_const", observed(), mk(9'h100, 0, 1, 0, 0, 0, 0));
    drive(1, 5, 0, 0, 0, 2'b00, 1);
    step("iv00_err");

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9),
            $urandom_range(0, 1),
            ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b11,
            ($urandom_range(0, 7) != 0));
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
